result_bcd_converter: RTL

Sequential binary-to-BCD converter on the consumer end of the exponent FSMD's result interface. It captures the 16-bit result when the FSMD's done flag rises and converts it to five BCD digits with a one-shift-per-cycle double-dabble. It then presents the digits to the LCD controller under a valid/ack handshake. A one-deep pending buffer absorbs a new result that arrives while a conversion is in progress or unacknowledged.

---
 rtl/result_bcd_converter_pkg.sv | 16 +
 rtl/result_bcd_converter_if.sv | 23 ++
 rtl/result_bcd_converter_bcd_add3_stage.sv | 18 +
 rtl/result_bcd_converter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/result_bcd_converter_pkg.sv
// Shared types and widths for the result binary-to-BCD converter.
package result_bcd_converter_pkg;

    localparam int BIN_W = 16;
    localparam int DIG_N = 5;
    localparam int BCD_W = DIG_N * 4;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

endpackage

// File: rtl/result_bcd_converter_if.sv
// Result/digit handshake between the FSMD, the converter and the LCD controller.
interface result_bcd_converter_if;
    import result_bcd_converter_pkg::*;

    logic             done_i;
    logic [BIN_W-1:0] result_i;
    logic             ack_i;
    logic [BCD_W-1:0] digits_o;
    logic             valid_o;
    logic             busy_o;
    logic             overrun_o;

    modport master (
        output done_i, result_i, ack_i,
        input  digits_o, valid_o, busy_o, overrun_o
    );

    modport slave (
        input  done_i, result_i, ack_i,
        output digits_o, valid_o, busy_o, overrun_o
    );

endinterface

// File: rtl/result_bcd_converter_bcd_add3_stage.sv
// Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
module bcd_add3_stage
    import result_bcd_converter_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [BCD_W-1:0] bcd_adj
);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIG_N; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential 16-bit binary to 5-digit BCD converter with a one-deep pending buffer.
// Build option LEADING_ZERO_BLANK_EN replaces leading zero digits with the LCD blank code.
module result_bcd_converter
    import result_bcd_converter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    result_bcd_converter_if.slave bus
);

    conv_state_t      state, state_nxt;
    logic             done_q;
    logic             edge_armed;
    logic             new_result;
    logic             ack_in_done;
    logic [BIN_W-1:0] bin_sr;
    logic [BIN_W-1:0] pend_data;
    logic             pend_v;
    logic [BCD_W-1:0] bcd_sr;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_final;
    logic [BCD_W-1:0] digits_fmt;
    logic [3:0]       cnt;
    logic             load_new;
    logic             load_pend;
    logic             store_pend;
    logic             finish;

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = d;
        lead = 1'b1;
        for (int i = DIG_N - 1; i > 0; i--) begin
            if (lead && (d[i*4 +: 4] == 4'd0)) begin
                r[i*4 +: 4] = BLANK_DIGIT;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    assign digits_fmt = blank_leading(bcd_final);
`else
    assign digits_fmt = bcd_final;
`endif

    // A done level present when reset releases must fall once before an edge counts.
    assign new_result  = bus.done_i & ~done_q & edge_armed;
    assign ack_in_done = (state == ST_DONE) && bus.ack_i;
    assign bus.busy_o  = (state == ST_SHIFT);

    bcd_add3_stage u_add3 (
        .bcd     (bcd_sr),
        .bcd_adj (bcd_adj)
    );

    // The last shift's result, taken before it lands in the shift register.
    assign bcd_final = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_new   = 1'b0;
        load_pend  = 1'b0;
        store_pend = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (new_result) begin
                    load_new  = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                store_pend = new_result;
                if (cnt == 4'd15) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.ack_i) begin
                    if (pend_v) begin
                        load_pend  = 1'b1;
                        store_pend = new_result;
                        state_nxt  = ST_SHIFT;
                    end else if (new_result) begin
                        load_new  = 1'b1;
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    store_pend = new_result;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q        <= 1'b0;
            edge_armed    <= 1'b0;
            pend_v        <= 1'b0;
            cnt           <= 4'd0;
            bus.digits_o  <= '0;
            bus.valid_o   <= 1'b0;
            bus.overrun_o <= 1'b0;
        end else begin
            done_q <= bus.done_i;
            if (!bus.done_i) begin
                edge_armed <= 1'b1;
            end
            if (store_pend) begin
                pend_v <= 1'b1;
            end else if (load_pend) begin
                pend_v <= 1'b0;
            end
            // Consuming the buffer on the same edge frees the slot, so no overrun then.
            if (store_pend && pend_v && !load_pend) begin
                bus.overrun_o <= 1'b1;
            end
            if (load_new || load_pend) begin
                cnt <= 4'd0;
            end else if (state == ST_SHIFT) begin
                cnt <= cnt + 4'd1;
            end
            if (finish) begin
                bus.digits_o <= digits_fmt;
                bus.valid_o  <= 1'b1;
            end else if (ack_in_done) begin
                bus.valid_o  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_new) begin
            bin_sr <= bus.result_i;
            bcd_sr <= '0;
        end else if (load_pend) begin
            bin_sr <= pend_data;
            bcd_sr <= '0;
        end else if (state == ST_SHIFT) begin
            {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
        end
        if (store_pend) begin
            pend_data <= bus.result_i;
        end
    end

endmodule
